test_monitor: RTL and testbench

- Synthesizable end-of-test monitor that sits beside PipelinedCPU on the instruction and data memory buses, in both the simulation bench and the FPGA top.
- Replaces per-test hard-coded register peeks with a generic mechanism:
  - a tohost mailbox write terminates the test;
  - a parametrised bank of signature slots is captured from data-memory writes and compared against expected values;
  - a timeout counter and a PC-hang detector catch runaway programs.
- Reports status, fail code and cycle count.

---
 rtl/test_monitor_pkg.sv | 21 ++
 rtl/test_monitor_sig_slot.sv | 38 +++
 rtl/test_monitor.sv | 134 +++++++++++++
 tb/tb_test_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/test_monitor_pkg.sv
// Shared types and defaults for the end-of-test monitor.
package test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } mon_status_t;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
  localparam logic [31:0] SIG_BASE_DEF    = 32'h0000_1100;

  // A status from which only a re-arm moves the monitor again.
  function automatic logic is_terminal(input mon_status_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
  endfunction

endpackage

// File: rtl/test_monitor_sig_slot.sv
// One signature slot: byte-enable capture register, seen flag, compare.
module sig_slot #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr,
  input  logic [3:0]      be,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] exp_value,
  output logic            seen,
  output logic            match
);

  // Byte lanes reachable through the 4-bit byte enable.
  localparam int NB = (XLEN / 8 < 4) ? XLEN / 8 : 4;

  logic [XLEN-1:0] value;

  // Capture: clear on arm, otherwise merge enabled bytes on a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      seen  <= 1'b0;
    end else if (clr) begin
      value <= '0;
      seen  <= 1'b0;
    end else if (wr) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) value[b*8 +: 8] <= wdata[b*8 +: 8];
      seen <= 1'b1;
    end
  end

  assign match = (value == exp_value);

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: tohost mailbox, signature slots, timeout and PC-hang detection.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int          ALEN           = 32,
  parameter int          XLEN           = 32,
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEF,
  parameter logic [31:0] SIG_BASE       = SIG_BASE_DEF,
  parameter int          NUM_CHECKS     = 4,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter int          HANG_CYCLES    = 256,
  parameter int          CNT_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ALEN-1:0]            imem_addr,
  input  logic                       imem_en,
  input  logic [ALEN-1:0]            dmem_addr,
  input  logic [XLEN-1:0]            dmem_wdata,
  input  logic                       dmem_we,
  input  logic [3:0]                 dmem_be,
  input  logic [NUM_CHECKS*XLEN-1:0] exp_values,
  input  logic [NUM_CHECKS-1:0]      exp_valid,
  output logic [2:0]                 status,
  output logic                       done,
  output logic [XLEN-1:0]            fail_code,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [NUM_CHECKS-1:0]      sig_seen,
  output logic [NUM_CHECKS-1:0]      sig_match
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HW = $clog2(HANG_CYCLES) + 1;
  localparam logic [ALEN-1:0] TOHOST_A = ALEN'(TOHOST_ADDR);
  localparam logic [ALEN-1:0] SIG_A    = ALEN'(SIG_BASE);

  mon_status_t     state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [HW-1:0]   hang_cnt, hang_nxt;
  logic [ALEN-1:0] last_pc;
  logic            pc_vld;

  logic run, arm, tohost_term, sig_ok, pass, hang_hit, tmo_hit, same_pc;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^dmem_addr[1:0];

  assign run = (state == ST_RUN);
  assign arm = start && !run;

  // Terminating mailbox write; verdict uses slot state from before this edge.
  assign tohost_term = dmem_we && (dmem_be == 4'hF) &&
                       (dmem_addr[ALEN-1:2] == TOHOST_A[ALEN-1:2]) && dmem_wdata[0];
  assign sig_ok      = &(~exp_valid | (sig_seen & sig_match));
  assign pass        = sig_ok && (dmem_wdata == XLEN'(1));

  assign same_pc  = pc_vld && (imem_addr == last_pc);
  assign hang_nxt = !imem_en ? hang_cnt : (same_pc ? hang_cnt + 1'b1 : '0);
  assign hang_hit = imem_en && (hang_nxt == HW'(HANG_CYCLES - 1));
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next status: mailbox beats hang, hang beats timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (tohost_term)   state_nxt = pass ? ST_PASS : ST_FAIL;
        else if (hang_hit) state_nxt = ST_HANG;
        else if (tmo_hit)  state_nxt = ST_TIMEOUT;
      end
      default: if (start) state_nxt = ST_RUN;
    endcase
  end

  // Run counters, hang tracker and fail code; cleared on arm, frozen outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      tmo_cnt     <= '0;
      hang_cnt    <= '0;
      last_pc     <= '0;
      pc_vld      <= 1'b0;
      fail_code   <= '0;
      done        <= 1'b0;
    end else begin
      done <= is_terminal(state_nxt);
      if (arm) begin
        cycle_count <= '0;
        tmo_cnt     <= '0;
        hang_cnt    <= '0;
        last_pc     <= '0;
        pc_vld      <= 1'b0;
        fail_code   <= '0;
      end else if (run) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        tmo_cnt  <= tmo_cnt + 1'b1;
        hang_cnt <= hang_nxt;
        if (imem_en) begin
          last_pc <= imem_addr;
          pc_vld  <= 1'b1;
        end
        if (tohost_term) fail_code <= dmem_wdata;
      end
    end
  end

  assign status = state;

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_slot
    logic hit;
    assign hit = run && dmem_we &&
                 (dmem_addr[ALEN-1:2] == SIG_A[ALEN-1:2] + (ALEN-2)'(i));
    sig_slot #(.XLEN(XLEN)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (arm),
      .wr        (hit),
      .be        (dmem_be),
      .wdata     (dmem_wdata),
      .exp_value (exp_values[i*XLEN +: XLEN]),
      .seen      (sig_seen[i]),
      .match     (sig_match[i])
    );
  end

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench: default-parameter monitor plus a short-timeout instance on shared buses.
module tb_test_monitor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  imem_addr = '0;
  logic         imem_en = 1'b0;
  logic [31:0]  dmem_addr = '0;
  logic [31:0]  dmem_wdata = '0;
  logic         dmem_we = 1'b0;
  logic [3:0]   dmem_be = '0;
  logic [127:0] exp_values;
  logic [3:0]   exp_valid = 4'hF;

  logic [2:0]  status_d, status_t;
  logic        done_d, done_t;
  logic [31:0] fail_code_d, fail_code_t;
  logic [31:0] cyc_d, cyc_t;
  logic [3:0]  seen_d, seen_t, match_d, match_t;

  int passes = 0;
  int total  = 0;

  localparam logic [127:0] EXP_DEF = {32'h44, 32'h33, 32'h22, 32'h11};

  always #5 clk = ~clk;

  test_monitor dut_d (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_en(imem_en),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .exp_values(exp_values), .exp_valid(exp_valid),
    .status(status_d), .done(done_d), .fail_code(fail_code_d), .cycle_count(cyc_d),
    .sig_seen(seen_d), .sig_match(match_d)
  );

  test_monitor #(.TIMEOUT_CYCLES(50), .HANG_CYCLES(1000)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_en(imem_en),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .exp_values(exp_values), .exp_valid(exp_valid),
    .status(status_t), .done(done_t), .fail_code(fail_code_t), .cycle_count(cyc_t),
    .sig_seen(seen_t), .sig_match(match_t)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_be    = be;
    dmem_we    = 1'b1;
    tick(1);
    dmem_we    = 1'b0;
  endtask

  task automatic store_sigs(input logic [31:0] s2);
    store(32'h1100, 32'h11, 4'hF);
    store(32'h1104, 32'h22, 4'hF);
    store(32'h1108, s2,     4'hF);
    store(32'h110C, 32'h44, 4'hF);
  endtask

  // Reset pulse placed mid-cycle, away from clock edges.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    exp_values = EXP_DEF;

    // Reset state
    tick(2);
    chk("rst_status", 64'(status_d), 64'd0);
    chk("rst_done", 64'(done_d), 64'd0);
    chk("rst_fail_code", 64'(fail_code_d), 64'd0);
    chk("rst_cycle", 64'(cyc_d), 64'd0);
    chk("rst_seen", 64'(seen_d), 64'd0);
    #2 rst_n = 1'b1;

    // All signatures match, tohost=1 -> PASS
    arm();
    chk("arm_status", 64'(status_d), 64'd1);
    chk("arm_cycle", 64'(cyc_d), 64'd0);
    store_sigs(32'h33);
    chk("pre_pass_status", 64'(status_d), 64'd1);
    chk("pre_pass_done", 64'(done_d), 64'd0);
    store(32'h1000, 32'h1, 4'hF);
    chk("pass_status", 64'(status_d), 64'd2);
    chk("pass_done", 64'(done_d), 64'd1);
    chk("pass_fail_code", 64'(fail_code_d), 64'd1);
    chk("pass_match", 64'(match_d), 64'hF);
    chk("pass_seen", 64'(seen_d), 64'hF);
    chk("pass_cycle", 64'(cyc_d), 64'd5);
    tick(3);
    chk("frozen_cycle", 64'(cyc_d), 64'd5);
    chk("frozen_status", 64'(status_d), 64'd2);

    // Re-arm from PASS clears; slot 2 wrong -> FAIL
    arm();
    chk("rearm_status", 64'(status_d), 64'd1);
    chk("rearm_seen", 64'(seen_d), 64'd0);
    chk("rearm_fail_code", 64'(fail_code_d), 64'd0);
    store_sigs(32'h30);
    store(32'h1000, 32'h1, 4'hF);
    chk("badsig_status", 64'(status_d), 64'd3);
    chk("badsig_match", 64'(match_d), 64'hB);
    chk("badsig_fail_code", 64'(fail_code_d), 64'd1);

    // Signatures match but tohost=7 -> FAIL with code 7
    arm();
    store_sigs(32'h33);
    store(32'h1000, 32'h7, 4'hF);
    chk("code7_status", 64'(status_d), 64'd3);
    chk("code7_fail_code", 64'(fail_code_d), 64'd7);
    chk("code7_done", 64'(done_d), 64'd1);

    // Byte-enable merge, then a progress write keeps RUN
    arm();
    exp_values[31:0] = 32'h1111_AB11;
    store(32'h1100, 32'h1111_1111, 4'hF);
    store(32'h1100, 32'h0000_AB00, 4'b0010);
    chk("merge_match0", 64'(match_d[0]), 64'd1);
    chk("merge_seen", 64'(seen_d), 64'h1);
    store(32'h1000, 32'h2, 4'hF);
    chk("progress_status", 64'(status_d), 64'd1);
    chk("progress_done", 64'(done_d), 64'd0);
    exp_values = EXP_DEF;
    tick(2);

    // Asynchronous reset mid-RUN, checked before the next edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_status", 64'(status_d), 64'd0);
    chk("async_cycle", 64'(cyc_d), 64'd0);
    chk("async_seen", 64'(seen_d), 64'd0);
    chk("async_done", 64'(done_d), 64'd0);
    #1 rst_n = 1'b1;
    tick(1);

    // Runaway loop over two PCs: short-timeout instance times out at 50
    arm();
    imem_en = 1'b1;
    for (int i = 0; i < 49; i++) begin
      imem_addr = (i % 2 == 0) ? 32'h0 : 32'h4;
      tick(1);
    end
    chk("pre_tmo_status", 64'(status_t), 64'd1);
    chk("pre_tmo_cycle", 64'(cyc_t), 64'd49);
    imem_addr = 32'h8;
    tick(1);
    chk("tmo_status", 64'(status_t), 64'd4);
    chk("tmo_cycle", 64'(cyc_t), 64'd50);
    chk("tmo_fail_code", 64'(fail_code_t), 64'd0);
    chk("tmo_default_run", 64'(status_d), 64'd1);
    imem_en = 1'b0;
    pulse_reset();
    tick(1);

    // tohost=1 on the same edge as timeout expiry -> PASS
    arm();
    store_sigs(32'h33);
    tick(45);
    chk("race_pre_status", 64'(status_t), 64'd1);
    store(32'h1000, 32'h1, 4'hF);
    chk("race_status", 64'(status_t), 64'd2);
    chk("race_cycle", 64'(cyc_t), 64'd50);
    chk("race_default", 64'(status_d), 64'd2);

    // Default instance: j . loop -> HANG on the 256th fetch of one PC
    arm();
    imem_en   = 1'b1;
    imem_addr = 32'h80;
    tick(255);
    chk("pre_hang_status", 64'(status_d), 64'd1);
    tick(1);
    chk("hang_status", 64'(status_d), 64'd5);
    chk("hang_done", 64'(done_d), 64'd1);
    chk("hang_fail_code", 64'(fail_code_d), 64'd0);
    imem_en = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
